// File: rtl/rx_packet_buffer.sv
// USB receive packet buffer: PID decode, token field capture and a speculative
// byte FIFO (CRC16 held back) that is committed or rolled back at end of packet.
module rx_packet_buffer #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_byte,
  input  logic              byte_complete,
  input  logic              load_pid,
  input  logic              load_data,
  input  logic              load_error,
  input  logic              load_done,
  input  logic              pop,
  input  logic              flush,
  output logic [7:0]        rx_fifo_rdata,
  output logic              rx_data_ready,
  output logic [ADDR_W:0]   buffer_occupancy,
  output logic [2:0]        rx_packet,
  output logic              rx_transfer_active,
  output logic              rx_error,
  output logic [6:0]        token_addr,
  output logic [3:0]        token_endp
);
  typedef enum logic [2:0] {IDLE, TOKEN, DATA, HSHAKE, COMMIT, DISCARD} state_t;
  localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);

  state_t          state, state_nxt;
  logic [7:0]      mem [DEPTH];
  logic [ADDR_W:0] wr_ptr, rd_ptr, commit_ptr, wr_lvl;
  logic [7:0]      h1, h0, nbytes;
  logic [1:0]      hcnt;
  logic            bad;
  logic [2:0]      pid_code, dec_code;
  logic [6:0]      addr_tmp;
  logic [3:0]      endp_tmp;
  logic            pid_ev, data_ev, active, dec_ok, len_ok, push, full;

  assign pid_ev           = load_pid && byte_complete;
  assign data_ev          = load_data && byte_complete;
  assign active           = state inside {TOKEN, DATA, HSHAKE};
  assign wr_lvl           = wr_ptr - rd_ptr;
  assign full             = (wr_lvl == FULL_LVL);
  // The holdback is full, so the oldest held byte is payload, not CRC.
  assign push             = (state == DATA) && data_ev && (hcnt == 2'd2);
  assign buffer_occupancy = commit_ptr - rd_ptr;
  assign rx_data_ready    = (commit_ptr != rd_ptr);
  assign rx_fifo_rdata    = rx_data_ready ? mem[rd_ptr[ADDR_W-1:0]] : 8'h00;

  always_comb begin
    dec_code = 3'd0;
    case (rx_byte[3:0])
      4'b0001: dec_code = 3'd1;
      4'b1001: dec_code = 3'd2;
      4'b0011: dec_code = 3'd3;
      4'b1011: dec_code = 3'd4;
      4'b0010: dec_code = 3'd5;
      4'b1010: dec_code = 3'd6;
      4'b1110: dec_code = 3'd7;
      default: dec_code = 3'd0;
    endcase
    dec_ok = (dec_code != 3'd0) && (rx_byte[7:4] == ~rx_byte[3:0]);
  end

  always_comb begin
    state_nxt = state;
    len_ok    = 1'b1;
    case (state)
      TOKEN:   len_ok = (nbytes == 8'd2);
      DATA:    len_ok = (nbytes >= 8'd2);
      default: len_ok = 1'b1;
    endcase
    case (state)
      IDLE:
        if (pid_ev) begin
          if (!dec_ok)               state_nxt = HSHAKE;
          else if (dec_code <= 3'd2) state_nxt = TOKEN;
          else if (dec_code <= 3'd4) state_nxt = DATA;
          else                       state_nxt = HSHAKE;
        end
      TOKEN, DATA, HSHAKE:
        if (load_error || (load_done && (bad || !len_ok))) state_nxt = DISCARD;
        else if (load_done)                                state_nxt = COMMIT;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk)
    if (push && !full) mem[wr_ptr[ADDR_W-1:0]] <= h1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      commit_ptr         <= '0;
      h1                 <= 8'h00;
      h0                 <= 8'h00;
      hcnt               <= 2'd0;
      nbytes             <= 8'd0;
      bad                <= 1'b0;
      pid_code           <= 3'd0;
      addr_tmp           <= 7'd0;
      endp_tmp           <= 4'd0;
      rx_packet          <= 3'd0;
      rx_transfer_active <= 1'b0;
      rx_error           <= 1'b0;
      token_addr         <= 7'd0;
      token_endp         <= 4'd0;
    end else begin
      state <= state_nxt;
      if (pop && rx_data_ready) rd_ptr <= rd_ptr + 1'b1;
      case (state)
        IDLE:
          if (pid_ev) begin
            pid_code           <= dec_ok ? dec_code : 3'd0;
            bad                <= !dec_ok;
            rx_error           <= 1'b0;
            rx_transfer_active <= 1'b1;
            nbytes             <= 8'd0;
            hcnt               <= 2'd0;
          end else if (load_error || load_done) begin
            rx_error <= 1'b1;
          end
        TOKEN, DATA, HSHAKE:
          if (data_ev) begin
            if (nbytes != 8'hff) nbytes <= nbytes + 8'd1;
            if (state == TOKEN) begin
              if (nbytes == 8'd0) begin
                addr_tmp    <= rx_byte[6:0];
                endp_tmp[0] <= rx_byte[7];
              end else if (nbytes == 8'd1) begin
                endp_tmp[3:1] <= rx_byte[2:0];
              end
            end
            if (state == HSHAKE) bad <= 1'b1;
            if (state == DATA) begin
              h1 <= h0;
              h0 <= rx_byte;
              if (hcnt != 2'd2) hcnt <= hcnt + 2'd1;
              if (push) begin
                if (full) bad <= 1'b1;
                else      wr_ptr <= wr_ptr + 1'b1;
              end
            end
          end
        COMMIT: begin
          commit_ptr         <= wr_ptr;
          rx_packet          <= pid_code;
          rx_transfer_active <= 1'b0;
          if (pid_code <= 3'd2) begin
            token_addr <= addr_tmp;
            token_endp <= endp_tmp;
          end
        end
        DISCARD: begin
          wr_ptr             <= commit_ptr;
          rx_error           <= 1'b1;
          rx_transfer_active <= 1'b0;
        end
        default: ;
      endcase
      // Flush overrides any same-cycle pointer update; an open packet must discard.
      if (flush) begin
        rd_ptr     <= '0;
        wr_ptr     <= '0;
        commit_ptr <= '0;
        hcnt       <= 2'd0;
        h1         <= 8'h00;
        h0         <= 8'h00;
        if (active) bad <= 1'b1;
      end
    end
  end
endmodule

// File: doc/rx_packet_buffer.md
# rx_packet_buffer

Downstream stage of the USB receiver control unit: consumes its `load_pid`/`load_data`/`load_error`/`load_done` strobes together with the assembled receive byte. It decodes and validates the PID and captures token address/endpoint fields. Data payloads are staged into a speculative FIFO with the 2-byte CRC16 stripped, then committed or rolled back at end of packet. Committed bytes are drained by the AHB-Lite slave side via `pop`.

## Interface
- `DEPTH`, 64, FIFO depth in bytes (power of two)
- `ADDR_W`, 6, log2(DEPTH)

- `clk` in 1 system clock
- `rst` in 1 synchronous, active-high reset
- `rx_byte` in 8 byte from RX shift register, valid when `byte_complete`=1
- `byte_complete` in 1 one-cycle pulse per received byte
- `load_pid` `load_data` `load_error` `load_done` in 1 each, RCU state strobes (levels)
- `pop` in 1 consume FIFO head
- `flush` in 1 clear FIFO and staging
- `rx_fifo_rdata` out 8 FIFO head (show-ahead)
- `rx_data_ready` out 1 committed occupancy > 0
- `buffer_occupancy` out ADDR_W+1 committed byte count
- `rx_packet` out 3 last committed packet: 0 none, 1 OUT, 2 IN, 3 DATA0, 4 DATA1, 5 ACK, 6 NAK, 7 STALL
- `rx_transfer_active` out 1 packet in progress
- `rx_error` out 1 sticky discard flag
- `token_addr` out 7, `token_endp` out 4 last committed token fields

## Operation
- PID capture: `load_pid && byte_complete`. Valid iff `rx_byte[7:4] == ~rx_byte[3:0]` and low nibble ∈ {0001 OUT, 1001 IN, 0011 DATA0, 1011 DATA1, 0010 ACK, 1010 NAK, 1110 STALL}; otherwise the bad flag is set.
- FSM states: IDLE, TOKEN, DATA, HSHAKE, COMMIT, DISCARD.
  - IDLE -> TOKEN/DATA/HSHAKE on PID capture by class. Invalid PID -> HSHAKE with bad flag set.
  - Capture also clears `rx_error` and the bad flag and sets `rx_transfer_active`.
  - Any active state -> DISCARD if `load_error`, or if `load_done` with bad flag set or length rule violated; else -> COMMIT on `load_done`.
  - COMMIT/DISCARD -> IDLE after one cycle.
- Data byte event: `load_data && byte_complete`, counted in `nbytes` (saturating at 255).
- TOKEN: byte1 -> `addr_tmp = b1[6:0]`, `endp_tmp[0] = b1[7]`; byte2 -> `endp_tmp[3:1] = b2[2:0]`. Length must be exactly 2.
- HSHAKE: any data byte sets the bad flag.
- DATA: 2-entry holdback `h1` (older) and `h0`. On a byte event when 2 bytes are already held, push `h1` to the FIFO at `wr_ptr`, shift `h1 <- h0`, `h0 <- rx_byte`. Held bytes at `load_done` are the CRC and are dropped. Length must be ≥ 2.
- FIFO push when `wr_ptr - rd_ptr == DEPTH`: byte dropped, bad flag set.
- COMMIT: `commit_ptr <- wr_ptr`; update `rx_packet` and, for tokens, `token_addr`/`token_endp`.
- DISCARD: `wr_ptr <- commit_ptr`; set `rx_error`; `rx_packet` unchanged.
- `load_error` or `load_done` in IDLE (e.g. sync failure): set `rx_error`, stay in IDLE.
- Read side sees committed data only. `pop` when occupancy 0 is ignored. Push and pop in the same cycle are both performed.
- `flush`: `rd_ptr = wr_ptr = commit_ptr = 0`; holdback cleared. If mid-packet, the bad flag is set so the packet discards.
- Pointers are ADDR_W+1 bits and wrap modulo 2·DEPTH; occupancy = `commit_ptr - rd_ptr`.

## Timing
- Reset (sync, `rst`=1 at edge): all pointers 0, FSM IDLE, all outputs 0 (`rx_fifo_rdata` 0).
- `rst` mid-packet aborts the packet with no commit; the first capture after reset starts clean.
- PID capture -> `rx_transfer_active`=1 the next cycle.
- `load_done` sampled at edge N -> COMMIT/DISCARD at N+1. `rx_data_ready`, `buffer_occupancy`, `rx_packet`, `rx_error` update at N+2; `rx_transfer_active`=0 at N+2.
- `rx_fifo_rdata` reflects the new head the cycle after `pop`.
- `load_error` and `load_done` in the same cycle -> DISCARD.

## Test plan
- DATA0 `0xC3`, payload `11 22 33`, CRC `AA BB`, `load_done` -> occupancy 3, `rx_packet`=3, pops yield `11,22,33`; `AA,BB` never appear.
- OUT `0xE1`, bytes `0x85 0x03` -> `token_addr`=0x05, `token_endp`=0x7, `rx_packet`=1, occupancy 0.
- DATA1 `0x4B` with 4 bytes, then `load_error` -> `rx_error`=1, occupancy unchanged from before the packet, `rx_packet` unchanged.
- Bad PID `0xC4` -> DISCARD, `rx_error`=1; next valid ACK `0xD2` -> `rx_error`=0, `rx_packet`=5.
- DEPTH+3 payload bytes (DEPTH+1 + CRC) -> overflow discard, occupancy 0. Then a full 64-byte payload -> occupancy 64.
- Pop during an incoming DATA packet: committed bytes drain in order, new bytes are invisible until commit. `flush` mid-packet -> occupancy 0 and that packet discards.
